// File: rtl/sfd_receiver.sv
// Serial frame receiver: hunts for the SFD, then deserialises data_len bits LSB first.
// Latency: sfd_det the cycle after the last SFD bit; dout_valid the cycle after the last data bit.
// Backpressure: none; the line is sampled every clk and each word is presented as a one-cycle strobe.
module sfd_receiver #(
   parameter int unsigned              data_len      = 8,
   parameter int unsigned              sfd_len_limit = 8,
   parameter logic [sfd_len_limit-1:0] sfd           = 8'b11010101
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx,
   output logic [data_len-1:0] dout,
   output logic                dout_valid,
   output logic                sfd_det,
   output logic                rx_busy,
   output logic [15:0]         frame_cnt
);

   localparam int unsigned     CW       = $clog2(data_len + 1);
   localparam logic [CW-1:0]   LAST_BIT = CW'(data_len - 1);

   typedef enum logic {HUNT, DATA} state_t;

   state_t                     state_q, state_d;
   logic [sfd_len_limit-1:0]   hs_q, hs_d;
   logic [data_len-1:0]        ds_q, ds_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [data_len-1:0]        dout_q, dout_d;
   logic                       dout_valid_q, dout_valid_d;
   logic                       sfd_det_q, sfd_det_d;
   logic                       rx_busy_q, rx_busy_d;
   logic [15:0]                frame_cnt_q, frame_cnt_d;

   // Shifted-in views of the line; the newest bit enters at the MSB so bit 0 is the oldest.
   logic [sfd_len_limit-1:0]   hs_next;
   logic [data_len-1:0]        ds_next;

   // Next-state and output logic: hunt for the delimiter, then collect one word.
   always_comb begin
      hs_next      = sfd_len_limit'({rx, hs_q} >> 1);
      ds_next      = data_len'({rx, ds_q} >> 1);
      state_d      = state_q;
      hs_d         = hs_q;
      ds_d         = ds_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      sfd_det_d    = 1'b0;
      rx_busy_d    = rx_busy_q;
      frame_cnt_d  = frame_cnt_q;
      case (state_q)
         HUNT: begin
            hs_d = hs_next;
            if (hs_next == sfd) begin
               sfd_det_d = 1'b1;
               state_d   = DATA;
               cnt_d     = '0;
               rx_busy_d = 1'b1;
            end
         end
         DATA: begin
            // The line is not searched here: a payload equal to the SFD is just data.
            ds_d  = ds_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               dout_d       = ds_next;
               dout_valid_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               rx_busy_d    = 1'b0;
               state_d      = HUNT;
               cnt_d        = '0;
               // Clearing the hunt shifter keeps data-tail bits out of the next match.
               hs_d         = '0;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // State and output registers; reset discards any partial word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= HUNT;
         hs_q         <= '0;
         ds_q         <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         sfd_det_q    <= 1'b0;
         rx_busy_q    <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         hs_q         <= hs_d;
         ds_q         <= ds_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sfd_det_q    <= sfd_det_d;
         rx_busy_q    <= rx_busy_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign sfd_det    = sfd_det_q;
   assign rx_busy    = rx_busy_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sfd_receiver.sv
// Directed bench for sfd_receiver: idle line, single frames, back-to-back frames,
// near-miss delimiter, mid-frame reset and a transmitter-style frame.
module tb_sfd_receiver;

   localparam logic [7:0] SFD = 8'b11010101;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b0;
   logic [7:0] dout;
   logic       dout_valid;
   logic       sfd_det;
   logic       rx_busy;
   logic [15:0] frame_cnt;

   // Transmitter-side handshake used to frame the last test.
   logic       tr_start = 1'b0;
   logic [7:0] din = 8'h00;

   int total = 0;
   int passed = 0;

   int cyc = 0;
   int sfd_cnt = 0;
   int dv_cnt = 0;
   int last_dv = 0;
   int prev_dv = 0;
   int busy_seen = 0;
   int overlap = 0;
   int base_sfd, base_dv;

   sfd_receiver dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .dout       (dout),
      .dout_valid (dout_valid),
      .sfd_det    (sfd_det),
      .rx_busy    (rx_busy),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   // Pulse bookkeeping sampled on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (sfd_det === 1'b1) sfd_cnt = sfd_cnt + 1;
      if (dout_valid === 1'b1) begin
         dv_cnt  = dv_cnt + 1;
         prev_dv = last_dv;
         last_dv = cyc;
      end
      if (rx_busy === 1'b1) busy_seen = 1;
      if (sfd_det === 1'b1 && dout_valid === 1'b1) overlap = 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Drive one line bit, let the DUT sample it, then settle 1 time unit.
   task automatic step(input logic b);
      rx = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) step(v[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   // Serial transmitter stage: start pulse, then SFD and payload LSB first.
   task automatic serial_tx(input logic [7:0] d);
      din = d;
      tr_start = 1'b1;
      step(1'b0);
      tr_start = 1'b0;
      send_bits({8'h00, SFD}, 8);
      send_bits({8'h00, din}, 8);
   endtask

   initial begin
      // ---- reset state ----
      reset = 1'b1;
      step(1'b0);
      step(1'b0);
      chk("rst_dout", {24'd0, dout}, 32'h0);
      chk("rst_dout_valid", {31'd0, dout_valid}, 32'h0);
      chk("rst_sfd_det", {31'd0, sfd_det}, 32'h0);
      chk("rst_rx_busy", {31'd0, rx_busy}, 32'h0);
      chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'h0);
      reset = 1'b0;

      // ---- 1: idle line never matches ----
      idle(50);
      chk("idle_sfd_pulses", sfd_cnt, 0);
      chk("idle_dv_pulses", dv_cnt, 0);
      chk("idle_busy_seen", busy_seen, 0);
      chk("idle_frame_cnt", {16'd0, frame_cnt}, 32'h0);

      // ---- 2: SFD + 0xA5 ----
      send_bits({8'h00, SFD}, 8);
      chk("t2_sfd_det", {31'd0, sfd_det}, 32'h1);
      chk("t2_rx_busy", {31'd0, rx_busy}, 32'h1);
      send_bits(16'h00A5, 7);
      chk("t2_no_early_dv", {31'd0, dout_valid}, 32'h0);
      step(1'b1);                       // bit 7 of 0xA5
      chk("t2_dout_valid", {31'd0, dout_valid}, 32'h1);
      chk("t2_dout", {24'd0, dout}, 32'hA5);
      chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'h1);
      chk("t2_busy_clear", {31'd0, rx_busy}, 32'h0);
      idle(1);
      chk("t2_dv_one_cycle", {31'd0, dout_valid}, 32'h0);
      chk("t2_dout_held", {24'd0, dout}, 32'hA5);
      idle(4);

      // ---- 3: back-to-back frames 0x3C, 0xD5 ----
      base_sfd = sfd_cnt;
      send_bits({8'h00, SFD}, 8);
      send_bits(16'h003C, 8);
      chk("t3_dv1", {31'd0, dout_valid}, 32'h1);
      chk("t3_dout1", {24'd0, dout}, 32'h3C);
      send_bits({8'h00, SFD}, 8);
      chk("t3_sfd2", {31'd0, sfd_det}, 32'h1);
      send_bits(16'h00D5, 8);
      chk("t3_dv2", {31'd0, dout_valid}, 32'h1);
      chk("t3_dout2", {24'd0, dout}, 32'hD5);
      idle(12);
      chk("t3_dv_spacing", last_dv - prev_dv, 16);
      chk("t3_sfd_pulses", sfd_cnt - base_sfd, 2);
      chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'h3);

      // ---- 4: near miss then real SFD + 0x01 ----
      base_sfd = sfd_cnt;
      send_bits(16'h00D4, 8);
      idle(4);
      chk("t4_near_miss", sfd_cnt - base_sfd, 0);
      send_bits({8'h00, SFD}, 8);
      send_bits(16'h0001, 8);
      chk("t4_dout", {24'd0, dout}, 32'h01);
      idle(4);
      chk("t4_sfd_pulses", sfd_cnt - base_sfd, 1);
      chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'h4);

      // ---- 5: reset at data bit 4, then 0x7E ----
      base_dv = dv_cnt;
      send_bits({8'h00, SFD}, 8);
      send_bits(16'h005A, 4);
      reset = 1'b1;
      step(1'b1);                       // bit 4 of 0x5A
      reset = 1'b0;
      chk("t5_dout_cleared", {24'd0, dout}, 32'h0);
      chk("t5_busy_cleared", {31'd0, rx_busy}, 32'h0);
      chk("t5_frame_cnt_cleared", {16'd0, frame_cnt}, 32'h0);
      step(1'b0);
      step(1'b1);
      step(1'b0);                       // bits 5..7 of 0x5A
      idle(10);
      chk("t5_no_dv", dv_cnt - base_dv, 0);
      send_bits({8'h00, SFD}, 8);
      send_bits(16'h007E, 8);
      chk("t5_dv", {31'd0, dout_valid}, 32'h1);
      chk("t5_dout", {24'd0, dout}, 32'h7E);
      chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'h1);
      idle(4);

      // ---- 6: transmitter-style frame 0xC3 ----
      serial_tx(8'hC3);
      chk("t6_dv", {31'd0, dout_valid}, 32'h1);
      chk("t6_dout", {24'd0, dout}, 32'hC3);
      chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'h2);
      idle(4);

      chk("no_sfd_dv_overlap", overlap, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
